// File: rtl/seg_capture.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus: waits for each anode slot
// to settle, decodes the glyph per position and flags complete frames. Optional macro: SEGCAP_DP_EN.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] digit_ok,
  output logic [3:0] dp_seen,
  output logic       frame_done,
  output logic       overlap_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

`ifdef SEGCAP_DP_EN
  localparam int SMP_W = 12;
  logic [SMP_W-1:0] smp_d;
  assign smp_d = {an, seg, dp};
`else
  localparam int SMP_W = 11;
  logic [SMP_W-1:0] smp_d;
  logic             unused_dp;
  assign smp_d     = {an, seg};
  assign unused_dp = dp;
`endif

  // smp_q is the current registered sample; smp_prev_q the one before it.
  logic [SMP_W-1:0] smp_q, smp_prev_q;
  logic [7:0]       cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       digit_q [4];
  logic [3:0]       digit_d [4];
  logic [3:0]       ok_q, ok_d;
  logic [3:0]       mask_q, mask_d;
  logic             frame_q, frame_d;
  logic             ovl_q, ovl_d;
`ifdef SEGCAP_DP_EN
  logic [3:0]       dps_q, dps_d;
`endif

  logic [3:0] an_d, an_q;
  logic [6:0] seg_q;
  logic       change;
  logic       cap_en;
  logic [1:0] cap_pos;
  logic [3:0] cap_bit;
  logic [3:0] dec_nib;
  logic       dec_ok;

  assign an_d   = smp_d[SMP_W-1 -: 4];
  assign an_q   = smp_q[SMP_W-1 -: 4];
  assign seg_q  = smp_q[SMP_W-5 -: 7];
  assign change = (smp_d != smp_q);

  // Segments arrive active-low; the table is written in active-high gfedcba.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (~seg_q)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    cap_pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_q[i]) cap_pos = 2'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    ovl_d   = 1'b0;
    if (change)                cnt_d = 8'd0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (an_d != 4'hF) state_d = SETTLE;
      end
      SETTLE: begin
        if (change) begin
          state_d = (an_d == 4'hF) ? IDLE : SETTLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          if ($onehot(~an_q)) cap_en = 1'b1;
          else                ovl_d  = 1'b1;
        end
      end
      HELD: begin
        if (change) state_d = (an_d == 4'hF) ? IDLE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap_bit = 4'b0001 << cap_pos;

  always_comb begin
    digit_d = digit_q;
    ok_d    = ok_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
`ifdef SEGCAP_DP_EN
    dps_d   = dps_q;
`endif
    if (cap_en) begin
      digit_d[cap_pos] = dec_ok ? dec_nib : 4'h0;
      ok_d[cap_pos]    = dec_ok;
`ifdef SEGCAP_DP_EN
      dps_d[cap_pos]   = ~smp_q[0];
`endif
      if ((mask_q | cap_bit) == 4'hF) begin
        frame_d = 1'b1;
        mask_d  = 4'h0;
      end else begin
        mask_d  = mask_q | cap_bit;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q      <= '1;
      smp_prev_q <= '1;
      cnt_q      <= 8'd0;
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      ok_q       <= 4'h0;
      mask_q     <= 4'h0;
      frame_q    <= 1'b0;
      ovl_q      <= 1'b0;
`ifdef SEGCAP_DP_EN
      dps_q      <= 4'h0;
`endif
    end else begin
      smp_q      <= smp_d;
      smp_prev_q <= smp_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      digit_q    <= digit_d;
      ok_q       <= ok_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
      ovl_q      <= ovl_d;
`ifdef SEGCAP_DP_EN
      dps_q      <= dps_d;
`endif
    end
  end

  // The previous sample is kept for observability; change detection looks one sample ahead.
  logic unused_prev;
  assign unused_prev = ^smp_prev_q;

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign digit_ok    = ok_q;
  assign frame_done  = frame_q;
  assign overlap_err = ovl_q;
`ifdef SEGCAP_DP_EN
  assign dp_seen     = dps_q;
`else
  assign dp_seen     = 4'h0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: frame capture, glitch rejection, overlap, blank glyph,
// short slots and reset mid-window. Expected dp_seen follows SEGCAP_DP_EN.
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit3, digit2, digit1, digit0, digit_ok, dp_seen;
  logic       frame_done, overlap_err;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int ov_count = 0;

  // Active-low gfedcba glyphs
  localparam logic [6:0] G1 = 7'h79, G3 = 7'h30, G5 = 7'h12, G7 = 7'h78;
  localparam logic [6:0] G8 = 7'h00, GA = 7'h08, GF = 7'h0E, BLANK = 7'h7F;

`ifdef SEGCAP_DP_EN
  localparam logic [3:0] EXP_DP0 = 4'b0001;
`else
  localparam logic [3:0] EXP_DP0 = 4'b0000;
`endif

  seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .digit_ok(digit_ok), .dp_seen(dp_seen),
    .frame_done(frame_done), .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (overlap_err === 1'b1) ov_count++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
    an  = a;
    seg = s;
    dp  = d;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    drive(4'hF, BLANK, 1'b1);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(20);
    chk4("reset_digits", {digit3[0] | digit2[0] | digit1[0] | digit0[0],
                          |{digit3, digit2}, |{digit1, digit0}, 1'b0}, 4'h0);
    chk4("reset_digit0", digit0, 4'h0);
    chk4("reset_ok", digit_ok, 4'h0);
    chk4("reset_dp_seen", dp_seen, 4'h0);
    chk4("reset_frame_pulses", 4'(fd_count), 4'd0);
    chk4("reset_overlap_pulses", 4'(ov_count), 4'd0);
  endtask

  task automatic test_frame;
    drive(4'b0111, G1, 1'b1); tick(14);
    drive(4'b1011, GA, 1'b1); tick(14);
    drive(4'b1101, G7, 1'b1); tick(14);
    chk4("frame_no_early_done", 4'(fd_count), 4'd0);
    drive(4'b1110, GF, 1'b1);
    tick(4);
    chk4("frame_done_before_edge4", {3'b0, frame_done}, 4'd0);
    chk4("digit0_before_edge4", digit0, 4'h0);
    tick(1);
    chk4("frame_done_edge4", {3'b0, frame_done}, 4'd1);
    chk4("digit0_edge4", digit0, 4'hF);
    tick(1);
    chk4("frame_done_one_cycle", {3'b0, frame_done}, 4'd0);
    tick(8);
    chk4("frame_digit3", digit3, 4'h1);
    chk4("frame_digit2", digit2, 4'hA);
    chk4("frame_digit1", digit1, 4'h7);
    chk4("frame_digit0", digit0, 4'hF);
    chk4("frame_ok", digit_ok, 4'hF);
    chk4("frame_count", 4'(fd_count), 4'd1);
  endtask

  task automatic test_glitch;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1011, (k % 2 == 0) ? G1 : G7, 1'b1);
      tick(2);
    end
    chk4("glitch_no_capture", digit2, 4'hA);
    drive(4'b1011, G5, 1'b1);
    tick(4);
    chk4("glitch_before_settle", digit2, 4'hA);
    tick(1);
    chk4("glitch_settled", digit2, 4'h5);
    tick(5);
    chk4("glitch_digit2_held", digit2, 4'h5);
    chk4("glitch_no_frame", 4'(fd_count), 4'd1);
  endtask

  task automatic test_overlap;
    drive(4'b0011, G8, 1'b1);
    tick(4);
    chk4("overlap_before_edge4", {3'b0, overlap_err}, 4'd0);
    tick(1);
    chk4("overlap_pulse", {3'b0, overlap_err}, 4'd1);
    tick(5);
    chk4("overlap_count", 4'(ov_count), 4'd1);
    chk4("overlap_digit3", digit3, 4'h1);
    chk4("overlap_digit2", digit2, 4'h5);
    chk4("overlap_digit0", digit0, 4'hF);
  endtask

  task automatic test_short_slot;
    drive(4'b1101, G3, 1'b1);
    tick(3);
    drive(4'hF, BLANK, 1'b1);
    tick(6);
    chk4("short_slot_digit1", digit1, 4'h7);
    chk4("short_slot_ok", digit_ok, 4'hF);
  endtask

  task automatic test_blank_dp;
    drive(4'b1110, BLANK, 1'b1);
    tick(10);
    chk4("blank_digit0", digit0, 4'h0);
    chk4("blank_ok", digit_ok, 4'b1110);
    drive(4'b1110, G8, 1'b0);
    tick(10);
    chk4("g8_digit0", digit0, 4'h8);
    chk4("g8_ok", digit_ok, 4'hF);
    chk4("g8_dp_seen", dp_seen, EXP_DP0);
    chk4("blank_dp_no_frame", 4'(fd_count), 4'd1);
  endtask

  task automatic test_reset_mid;
    // Mask now holds positions 0 and 2; add 3 so only position 1 is missing.
    drive(4'b0111, GA, 1'b1);
    tick(14);
    chk4("three_seen_no_frame", 4'(fd_count), 4'd1);
    drive(4'b1101, G7, 1'b1);
    tick(2);
    reset = 1'b0;
    #1;
    chk4("midreset_digit3", digit3, 4'h0);
    chk4("midreset_digit0", digit0, 4'h0);
    chk4("midreset_ok", digit_ok, 4'h0);
    chk4("midreset_dp_seen", dp_seen, 4'h0);
    tick(2);
    reset = 1'b1;
    tick(4);
    chk4("post_reset_before_window", digit1, 4'h0);
    tick(1);
    chk4("post_reset_window", digit1, 4'h7);
    chk4("post_reset_no_frame", 4'(fd_count), 4'd1);
    tick(9);
    drive(4'b0111, G1, 1'b1); tick(14);
    drive(4'b1011, GA, 1'b1); tick(14);
    chk4("post_reset_partial", 4'(fd_count), 4'd1);
    drive(4'b1110, GF, 1'b1); tick(14);
    chk4("post_reset_frame", 4'(fd_count), 4'd2);
    chk4("post_reset_digits", {digit3[0], digit2[3], digit1[0], digit0[3]}, 4'b1111);
    chk4("post_reset_overlaps", 4'(ov_count), 4'd1);
  endtask

  initial begin
    reset = 1'b0;
    drive(4'hF, BLANK, 1'b1);
    test_reset();
    test_frame();
    test_glitch();
    test_overlap();
    test_short_slot();
    test_blank_dp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
